// File: rtl/register_file.sv
// Architectural register file with per-register rename tags and ROB operand forwarding.
// Optional feature macro: REG_COMMIT_BYPASS_EN (forward the committing value to same-cycle reads).
module register_file #(
    parameter int REG_WIDTH = 5,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,

    input  logic [REG_WIDTH-1:0] dec_rs1,
    input  logic [REG_WIDTH-1:0] dec_rs2,
    output logic                 dec_ready_j,
    output logic                 dec_ready_k,
    output logic [31:0]          dec_val_j,
    output logic [31:0]          dec_val_k,
    output logic [ROB_WIDTH-1:0] dec_dep_j,
    output logic [ROB_WIDTH-1:0] dec_dep_k,

    input  logic                 dec_rename_en,
    input  logic [REG_WIDTH-1:0] dec_rename_reg,
    input  logic [ROB_WIDTH-1:0] dec_rename_rob,

    output logic [ROB_WIDTH-1:0] rob_id_j,
    output logic [ROB_WIDTH-1:0] rob_id_k,
    input  logic                 rob_ready_j,
    input  logic                 rob_ready_k,
    input  logic [31:0]          rob_data_j,
    input  logic [31:0]          rob_data_k,

    input  logic                 commit_en,
    input  logic [REG_WIDTH-1:0] commit_reg_id,
    input  logic [31:0]          commit_data,
    input  logic [ROB_WIDTH-1:0] commit_rob_id,

    input  logic                 flush
);

    localparam int NUM_REGS = 1 << REG_WIDTH;

    typedef struct packed {
        logic                 ready;
        logic [31:0]          val;
        logic [ROB_WIDTH-1:0] dep;
    } operand_t;

    logic [31:0]          data_q [NUM_REGS];
    logic [31:0]          data_d [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q;
    logic [NUM_REGS-1:0]  busy_d;
    logic [ROB_WIDTH-1:0] tag_q  [NUM_REGS];
    logic [ROB_WIDTH-1:0] tag_d  [NUM_REGS];

    logic [NUM_REGS-1:0]  commit_sel;
    logic [NUM_REGS-1:0]  rename_sel;
    logic                 bypass_j;
    logic                 bypass_k;
    operand_t             op_j;
    operand_t             op_k;

    function automatic operand_t resolve(
        input logic [REG_WIDTH-1:0] idx,
        input logic                 busy,
        input logic [31:0]          data,
        input logic [ROB_WIDTH-1:0] tag,
        input logic                 bypass_hit,
        input logic                 rob_ready,
        input logic [31:0]          rob_data
    );
        operand_t res;
        res = '0;
        if (idx == '0) begin
            res.ready = 1'b1;
        end else if (!busy) begin
            res.ready = 1'b1;
            res.val   = data;
        end else if (bypass_hit) begin
            res.ready = 1'b1;
            res.val   = commit_data;
        end else if (rob_ready) begin
            res.ready = 1'b1;
            res.val   = rob_data;
        end else begin
            res.dep   = tag;
        end
        return res;
    endfunction

`ifdef REG_COMMIT_BYPASS_EN
    // Only a commit from the current producer may bypass; a stale id must not.
    assign bypass_j = commit_en && (commit_reg_id == dec_rs1) && (commit_rob_id == tag_q[dec_rs1]);
    assign bypass_k = commit_en && (commit_reg_id == dec_rs2) && (commit_rob_id == tag_q[dec_rs2]);
`else
    assign bypass_j = 1'b0;
    assign bypass_k = 1'b0;
`endif

    always_comb begin
        op_j = resolve(dec_rs1, busy_q[dec_rs1], data_q[dec_rs1], tag_q[dec_rs1],
                       bypass_j, rob_ready_j, rob_data_j);
        op_k = resolve(dec_rs2, busy_q[dec_rs2], data_q[dec_rs2], tag_q[dec_rs2],
                       bypass_k, rob_ready_k, rob_data_k);
    end

    assign dec_ready_j = op_j.ready;
    assign dec_val_j   = op_j.val;
    assign dec_dep_j   = op_j.dep;
    assign dec_ready_k = op_k.ready;
    assign dec_val_k   = op_k.val;
    assign dec_dep_k   = op_k.dep;
    assign rob_id_j    = tag_q[dec_rs1];
    assign rob_id_k    = tag_q[dec_rs2];

    // No valid/ready handshake: commit and rename are single-cycle pulses, qualified by rdy_in.
    always_comb begin
        commit_sel = '0;
        rename_sel = '0;
        if (commit_en) begin
            commit_sel[commit_reg_id] = 1'b1;
        end
        if (dec_rename_en && !flush) begin
            rename_sel[dec_rename_reg] = 1'b1;
        end
        commit_sel[0] = 1'b0;
        rename_sel[0] = 1'b0;
    end

    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy_in) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (commit_sel[r]) begin
                    data_d[r] = commit_data;
                end
                // Flush beats rename, rename beats the commit-clear.
                if (flush) begin
                    busy_d[r] = 1'b0;
                end else if (rename_sel[r]) begin
                    busy_d[r] = 1'b1;
                    tag_d[r]  = dec_rename_rob;
                end else if (commit_sel[r] && (tag_q[r] == commit_rob_id)) begin
                    busy_d[r] = 1'b0;
                end
            end
        end
        data_d[0] = '0;
        busy_d[0] = 1'b0;
        tag_d[0]  = '0;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_q <= '0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a vector table checked pre-edge each cycle,
// then a hand-written rename / reset-while-stalled sequence.
module tb_register_file;

`ifdef REG_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [4:0]  dec_rs1, dec_rs2;
    logic        dec_ready_j, dec_ready_k;
    logic [31:0] dec_val_j, dec_val_k;
    logic [3:0]  dec_dep_j, dec_dep_k;
    logic        dec_rename_en;
    logic [4:0]  dec_rename_reg;
    logic [3:0]  dec_rename_rob;
    logic [3:0]  rob_id_j, rob_id_k;
    logic        rob_ready_j, rob_ready_k;
    logic [31:0] rob_data_j, rob_data_k;
    logic        commit_en;
    logic [4:0]  commit_reg_id;
    logic [31:0] commit_data;
    logic [3:0]  commit_rob_id;
    logic        flush;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    register_file #(.REG_WIDTH(5), .ROB_WIDTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_ready_j(dec_ready_j), .dec_ready_k(dec_ready_k),
        .dec_val_j(dec_val_j), .dec_val_k(dec_val_k),
        .dec_dep_j(dec_dep_j), .dec_dep_k(dec_dep_k),
        .dec_rename_en(dec_rename_en), .dec_rename_reg(dec_rename_reg),
        .dec_rename_rob(dec_rename_rob),
        .rob_id_j(rob_id_j), .rob_id_k(rob_id_k),
        .rob_ready_j(rob_ready_j), .rob_ready_k(rob_ready_k),
        .rob_data_j(rob_data_j), .rob_data_k(rob_data_k),
        .commit_en(commit_en), .commit_reg_id(commit_reg_id),
        .commit_data(commit_data), .commit_rob_id(commit_rob_id),
        .flush(flush)
    );

    // Clock / reset
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        rrj;  logic [31:0] rdj;
        logic        rrk;  logic [31:0] rdk;
        logic        cen;  logic [4:0] creg; logic [31:0] cdata; logic [3:0] crob;
        logic        ren;  logic [4:0] rreg; logic [3:0] rrob;
        logic        fl, rdy;
        logic        e_rj; logic [31:0] e_vj; logic [3:0] e_dj, e_idj;
        logic        e_rk; logic [31:0] e_vk; logic [3:0] e_dk, e_idk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic rrj, input logic [31:0] rdj, input logic rrk, input logic [31:0] rdk,
        input logic cen, input logic [4:0] creg, input logic [31:0] cdata, input logic [3:0] crob,
        input logic ren, input logic [4:0] rreg, input logic [3:0] rrob,
        input logic fl, input logic rdy,
        input logic e_rj, input logic [31:0] e_vj, input logic [3:0] e_dj, input logic [3:0] e_idj,
        input logic e_rk, input logic [31:0] e_vk, input logic [3:0] e_dk, input logic [3:0] e_idk
    );
        vec_t t;
        t.rs1 = rs1; t.rs2 = rs2; t.rrj = rrj; t.rdj = rdj; t.rrk = rrk; t.rdk = rdk;
        t.cen = cen; t.creg = creg; t.cdata = cdata; t.crob = crob;
        t.ren = ren; t.rreg = rreg; t.rrob = rrob; t.fl = fl; t.rdy = rdy;
        t.e_rj = e_rj; t.e_vj = e_vj; t.e_dj = e_dj; t.e_idj = e_idj;
        t.e_rk = e_rk; t.e_vk = e_vk; t.e_dk = e_dk; t.e_idk = e_idk;
        return t;
    endfunction

    // Driver tasks
    task automatic idle_inputs();
        dec_rs1 = 0; dec_rs2 = 0;
        rob_ready_j = 0; rob_data_j = 0; rob_ready_k = 0; rob_data_k = 0;
        commit_en = 0; commit_reg_id = 0; commit_data = 0; commit_rob_id = 0;
        dec_rename_en = 0; dec_rename_reg = 0; dec_rename_rob = 0;
        flush = 0; rdy_in = 1;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_ports(input string tag, input vec_t t);
        chk({tag, " ready_j"}, 32'(dec_ready_j), 32'(t.e_rj));
        chk({tag, " val_j"},   dec_val_j,        t.e_vj);
        chk({tag, " dep_j"},   32'(dec_dep_j),   32'(t.e_dj));
        chk({tag, " rob_id_j"},32'(rob_id_j),    32'(t.e_idj));
        chk({tag, " ready_k"}, 32'(dec_ready_k), 32'(t.e_rk));
        chk({tag, " val_k"},   dec_val_k,        t.e_vk);
        chk({tag, " dep_k"},   32'(dec_dep_k),   32'(t.e_dk));
        chk({tag, " rob_id_k"},32'(rob_id_k),    32'(t.e_idk));
    endtask

    initial begin
        vec_t t;

        // Columns: rs1,rs2, rrj,rdj, rrk,rdk, cen,creg,cdata,crob, ren,rreg,rrob, flush,rdy,
        //          exp j: ready,val,dep,rob_id   exp k: ready,val,dep,rob_id
        vecs.push_back(v(5, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 3, 7,  0, 1,
                         1, 0, 0, 0,  1, 0, 0, 0));
        vecs.push_back(v(3, 3, 0, 0, 1, 32'hDEAD,  0, 0, 0, 0,  1, 4, 2,  0, 1,
                         0, 0, 7, 7,  1, 32'hDEAD, 0, 7));
        vecs.push_back(v(4, 0, 0, 0, 0, 0,  1, 3, 32'h1234, 7,  1, 3, 9,  0, 1,
                         0, 0, 2, 2,  1, 0, 0, 0));
        vecs.push_back(v(3, 3, 0, 0, 0, 0,  1, 3, 32'h5678, 7,  0, 0, 0,  0, 1,
                         0, 0, 9, 9,  0, 0, 9, 9));
        vecs.push_back(v(3, 3, 0, 0, 1, 32'hBEEF,  1, 5, 32'h55, 3,  1, 6, 1,  1, 1,
                         0, 0, 9, 9,  1, 32'hBEEF, 0, 9));
        vecs.push_back(v(4, 5, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 1,
                         1, 0, 0, 2,  1, 32'h55, 0, 0));
        vecs.push_back(v(3, 6, 0, 0, 0, 0,  0, 0, 0, 0,  1, 6, 1,  0, 1,
                         1, 32'h5678, 0, 9,  1, 0, 0, 0));
        vecs.push_back(v(6, 0, 0, 32'h1111, 0, 0,  1, 6, 32'hAA, 1,  0, 0, 0,  0, 1,
                         BYP, BYP ? 32'hAA : 32'h0, BYP ? 4'd0 : 4'd1, 1,  1, 0, 0, 0));
        vecs.push_back(v(6, 6, 0, 0, 0, 0,  1, 0, 32'hFF, 0,  1, 0, 5,  0, 1,
                         1, 32'hAA, 0, 1,  1, 32'hAA, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  1, 6, 32'h11, 1,  1, 7, 4,  0, 0,
                         1, 0, 0, 0,  1, 0, 0, 0));
        vecs.push_back(v(7, 6, 0, 0, 0, 0,  1, 7, 32'h77, 15,  1, 7, 15,  0, 1,
                         1, 0, 0, 0,  1, 32'hAA, 0, 1));
        vecs.push_back(v(7, 7, 0, 0, 1, 32'h99,  1, 7, 32'h7777, 15,  0, 0, 0,  0, 1,
                         BYP, BYP ? 32'h7777 : 32'h0, BYP ? 4'd0 : 4'd15, 15,
                         1, BYP ? 32'h7777 : 32'h99, 0, 15));
        vecs.push_back(v(7, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 1,
                         1, 32'h7777, 0, 0,  1, 0, 0, 0));

        idle_inputs();
        rst_in = 0;
        step();
        step();
        rst_in = 1;

        foreach (vecs[i]) begin
            t = vecs[i];
            dec_rs1 = t.rs1; dec_rs2 = t.rs2;
            rob_ready_j = t.rrj; rob_data_j = t.rdj;
            rob_ready_k = t.rrk; rob_data_k = t.rdk;
            commit_en = t.cen; commit_reg_id = t.creg; commit_data = t.cdata; commit_rob_id = t.crob;
            dec_rename_en = t.ren; dec_rename_reg = t.rreg; dec_rename_rob = t.rrob;
            flush = t.fl; rdy_in = t.rdy;
            #2;
            if (i == 12) t.e_idj = 4'd15;
            chk_ports($sformatf("vec%0d", i), t);
            step();
        end

        // Rename x8, then reset while rdy_in is low: reset must still clear state.
        idle_inputs();
        dec_rename_en = 1; dec_rename_reg = 8; dec_rename_rob = 3;
        step();
        idle_inputs();
        dec_rs1 = 8; dec_rs2 = 7;
        #2;
        exp_q.push_back(32'd0); exp_q.push_back(32'd3); exp_q.push_back(32'd3);
        exp_q.push_back(32'd1); exp_q.push_back(32'h7777);
        chk("seq x8 ready", 32'(dec_ready_j), exp_q.pop_front());
        chk("seq x8 dep",   32'(dec_dep_j),   exp_q.pop_front());
        chk("seq x8 robid", 32'(rob_id_j),    exp_q.pop_front());
        chk("seq x7 ready", 32'(dec_ready_k), exp_q.pop_front());
        chk("seq x7 val",   dec_val_k,        exp_q.pop_front());

        rdy_in = 0; rst_in = 0;
        step();
        rst_in = 1; rdy_in = 1;
        #2;
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        chk("rst x8 ready", 32'(dec_ready_j), exp_q.pop_front());
        chk("rst x8 val",   dec_val_j,        exp_q.pop_front());
        chk("rst x8 dep",   32'(dec_dep_j),   exp_q.pop_front());
        chk("rst x8 robid", 32'(rob_id_j),    exp_q.pop_front());
        chk("rst x7 val",   dec_val_k,        exp_q.pop_front());

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
